// File: rtl/cpu_sram_arbiter_pkg.sv
// ============================================================================
// Module   : cpu_sram_arbiter_pkg
// Brief    : Owner tags and FSM state encodings shared by the SRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_sram_arbiter_pkg;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_I = 2'd1,
    ARB_HOLD_D = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/cpu_sram_arbiter_order_fifo.sv
// ============================================================================
// Module   : cpu_sram_arbiter_order_fifo
// Brief    : In-order owner tracking FIFO; no bypass from push to head.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_sram_arbiter_order_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int c_ptr_w = $clog2(DEPTH);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w:0]     r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign full      = (r_count == DEPTH[c_ptr_w:0]);
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign head      = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_sram_arbiter.sv
// ============================================================================
// Module   : cpu_sram_arbiter
// Brief    : Shares one SRAM-like slave port between inst and data masters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_sram_arbiter
  import cpu_sram_arbiter_pkg::*;
#(
  parameter int MAX_OUT = 4,
  parameter int OWN_W   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inst_req,
  input  logic                      inst_wr,
  input  logic [1:0]                inst_size,
  input  logic [31:0]               inst_addr,
  input  logic [3:0]                inst_wstrb,
  input  logic [31:0]               inst_wdata,
  output logic                      inst_addr_ok,
  output logic                      inst_data_ok,
  output logic [31:0]               inst_rdata,
  input  logic                      data_req,
  input  logic                      data_wr,
  input  logic [1:0]                data_size,
  input  logic [31:0]               data_addr,
  input  logic [3:0]                data_wstrb,
  input  logic [31:0]               data_wdata,
  output logic                      data_addr_ok,
  output logic                      data_data_ok,
  output logic [31:0]               data_rdata,
  output logic                      m_req,
  output logic                      m_wr,
  output logic [1:0]                m_size,
  output logic [31:0]               m_addr,
  output logic [3:0]                m_wstrb,
  output logic [31:0]               m_wdata,
  input  logic                      m_addr_ok,
  input  logic                      m_data_ok,
  input  logic [31:0]               m_rdata,
  output logic [$clog2(MAX_OUT):0]  arb_outstanding,
  output logic                      arb_proto_err
);

  localparam logic [OWN_W-1:0] c_own_inst = OWN_W'(OWN_INST);
  localparam logic [OWN_W-1:0] c_own_data = OWN_W'(OWN_DATA);

  arb_state_t        r_state;
  logic [1:0]        r_fair_cnt;
  logic              r_proto_err;

  logic              w_req;
  logic [OWN_W-1:0]  w_owner;
  logic              w_sel_data;
  logic              w_pick_inst;
  logic              w_push;
  logic              w_pop;
  logic [OWN_W-1:0]  w_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;

  // Inst wins in IDLE only when data is idle or data has had three grants in a row.
  assign w_pick_inst = inst_req && (!data_req || (r_fair_cnt == 2'd3));

  always_comb begin
    w_req   = 1'b0;
    w_owner = c_own_inst;
    case (r_state)
      ARB_IDLE: begin
        if (!w_fifo_full) begin
          if (w_pick_inst) begin
            w_req   = 1'b1;
            w_owner = c_own_inst;
          end else if (data_req) begin
            w_req   = 1'b1;
            w_owner = c_own_data;
          end
        end
      end
      ARB_HOLD_I: begin
        w_req   = 1'b1;
        w_owner = c_own_inst;
      end
      ARB_HOLD_D: begin
        w_req   = 1'b1;
        w_owner = c_own_data;
      end
      default: begin
        w_req   = 1'b0;
        w_owner = c_own_inst;
      end
    endcase
  end

  assign w_sel_data = (w_owner == c_own_data);
  assign w_push     = w_req && m_addr_ok;
  assign w_pop      = m_data_ok && !w_fifo_empty;

  assign m_req   = w_req;
  assign m_wr    = w_sel_data ? data_wr    : inst_wr;
  assign m_size  = w_sel_data ? data_size  : inst_size;
  assign m_addr  = w_sel_data ? data_addr  : inst_addr;
  assign m_wstrb = w_sel_data ? data_wstrb : inst_wstrb;
  assign m_wdata = w_sel_data ? data_wdata : inst_wdata;

  assign inst_addr_ok = w_push && !w_sel_data;
  assign data_addr_ok = w_push && w_sel_data;

  assign inst_data_ok = w_pop && (w_head == c_own_inst);
  assign data_data_ok = w_pop && (w_head == c_own_data);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  assign arb_proto_err = r_proto_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_fair_cnt  <= 2'd0;
      r_proto_err <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_req && !m_addr_ok) begin
            r_state <= w_sel_data ? ARB_HOLD_D : ARB_HOLD_I;
          end
        end
        ARB_HOLD_I, ARB_HOLD_D: begin
          if (m_addr_ok) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase

      // Data grants are counted once, at acceptance, and saturate at three.
      if (!inst_req) begin
        r_fair_cnt <= 2'd0;
      end else if (w_push) begin
        if (!w_sel_data)              r_fair_cnt <= 2'd0;
        else if (r_fair_cnt != 2'd3)  r_fair_cnt <= r_fair_cnt + 2'd1;
      end

      if (m_data_ok && w_fifo_empty) r_proto_err <= 1'b1;
    end
  end

  cpu_sram_arbiter_order_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (OWN_W)
  ) u_order_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_owner),
    .pop       (w_pop),
    .head      (w_head),
    .count     (arb_outstanding),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

endmodule

`default_nettype wire
